// File: rtl/dft_pkg.sv
// Shared types and helpers for the DFT frame capture path.
package dft_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } dft_state_t;

   function automatic int frame_len(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Offset-binary to two's complement only needs the MSB flipped.
   function automatic logic to_twos_msb(input logic msb, input bit offset_bin);
      return offset_bin ? ~msb : msb;
   endfunction

endpackage

// File: rtl/dft_decimator.sv
// Keep-one-in-(ratio+1) strobe generator for the capture path.
module dft_decimator #(
   parameter int DECIM_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               en,
   input  logic [DECIM_W-1:0] ratio,
   output logic               keep
);

   logic [DECIM_W-1:0] count;

   assign keep = en && (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= (count == ratio) ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/dft_frame_capture.sv
// Arms on a pulse, starts on a trigger rising edge, and writes one decimated,
// format-converted frame of samples into the DFT FIFO write port.
module dft_frame_capture
   import dft_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 12,
   parameter int DECIM_W    = 4,
   parameter int OFFSET_BIN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               trig,
   input  logic [DECIM_W-1:0] decim,
   input  logic [DATA_W-1:0]  adc_data,
   input  logic               adc_valid,
   output logic [DATA_W-1:0]  wdata,
   output logic               wr,
   input  logic               full,
   output logic               busy,
   output logic               frame_done,
   output logic               overflow,
   output logic [1:0]         state
);

   localparam int FRAME_LEN = frame_len(ADDR_W);
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(FRAME_LEN - 1);

   dft_state_t         st;
   logic               trig_q;
   logic               rise;
   logic               arm_ok;
   logic               keep;
   logic [DECIM_W-1:0] decim_q;
   logic [ADDR_W:0]    scount;

   assign rise   = trig && !trig_q;
   assign arm_ok = arm && ((st == IDLE) || (st == DONE));
   assign busy   = (st == ARMED) || (st == CAPTURE);
   assign state  = st;

   dft_decimator #(.DECIM_W(DECIM_W)) u_decim (
      .clk   (clk),
      .rst   (rst),
      .load  ((st == ARMED) && rise),
      .en    ((st == CAPTURE) && adc_valid),
      .ratio (decim_q),
      .keep  (keep)
   );

   // FIFO port: wr is a one-cycle strobe with wdata; full is the not-ready
   // qualifier, sampled with the kept sample, and a refused sample is dropped
   // (flagged in overflow) rather than retried, so the frame stays time-aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= IDLE;
         trig_q     <= 1'b0;
         wdata      <= '0;
         wr         <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         decim_q    <= '0;
         scount     <= '0;
      end else begin
         trig_q     <= trig;
         wr         <= 1'b0;
         frame_done <= 1'b0;
         case (st)
            IDLE, DONE: begin
               if (arm_ok) begin
                  st       <= ARMED;
                  overflow <= 1'b0;
                  decim_q  <= decim;
                  scount   <= '0;
               end
            end
            ARMED: begin
               if (rise) st <= CAPTURE;
            end
            CAPTURE: begin
               if (keep) begin
                  if (full) begin
                     overflow <= 1'b1;
                  end else begin
                     wr    <= 1'b1;
                     wdata <= {to_twos_msb(adc_data[DATA_W-1], OFFSET_BIN != 0),
                               adc_data[DATA_W-2:0]};
                  end
                  scount <= scount + 1'b1;
                  if (scount == LAST) begin
                     frame_done <= 1'b1;
                     st         <= DONE;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
